weight_sram_reader: RTL and testbench

Read-side master for the 180 kB weight SRAM (five 16384×18b banks, 81920 words, one-cycle registered read). It accepts a burst command (base address, word count), issues sequential single-port RAM reads with CS/OE, absorbs the one-cycle read latency, and presents the sign-extended weights as a valid/ready stream to the PE array loader. A 2-entry output buffer with credit-based issue gives full throughput with lossless backpressure.

---
 rtl/weight_sram_reader_if.sv | 13 +
 rtl/weight_sram_reader.sv | 157 +++++++++++++++
 tb/tb_weight_sram_reader.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_sram_reader_if.sv
// Single-port weight SRAM bus: chip select, output enable, word address,
// active-low write request and 32-bit data in each direction.
interface sp_ram_intf;
    logic        cs;
    logic        oe;
    logic [31:0] addr;
    logic        W_req;
    logic [31:0] W_data;
    logic [31:0] R_data;

    modport master (output cs, oe, addr, W_req, W_data, input R_data);
    modport slave  (input cs, oe, addr, W_req, W_data, output R_data);
endinterface

// File: rtl/weight_sram_reader.sv
// Burst read master for the weight SRAM: 3 cycles command-to-first-word, then one word per cycle.
// Backpressure is absorbed by a 2-entry output buffer; reads issue only when a slot is guaranteed.

module weight_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] entry [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry[0] <= '0;
            entry[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = entry[rd_ptr];
endmodule

module weight_sram_reader #(
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 81920
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    sp_ram_intf.master        mem
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] issued;
    logic              pend;
    logic              issue;
    logic              pop;
    logic [1:0]        fifo_count;
    logic [2:0]        occ;
    logic [ADDR_W:0]   end_addr;
    logic              legal;
    logic [31:0]       push_data;
    logic              unused_rdata_hi;

    assign end_addr = {1'b0, base_addr} + {1'b0, length};
    assign legal    = (length != '0) && (end_addr <= (ADDR_W+1)'(DEPTH));

    assign pop = out_valid & out_ready;
    // Slots committed after this edge: current entries, plus the word landing now, minus the one leaving.
    assign occ   = {1'b0, fifo_count} + {2'b00, pend} - {2'b00, pop};
    assign issue = (state == RUN) && (issued < len_q) && (occ < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            base_q <= '0;
            len_q  <= '0;
            issued <= '0;
            pend   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            pend <= issue;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (legal) begin
                            base_q <= base_addr;
                            len_q  <= length;
                            issued <= '0;
                            busy   <= 1'b1;
                            state  <= RUN;
                        end else begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        issued <= issued + 1'b1;
                        if (issued + 1'b1 == len_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // occ == 0 also implies nothing is still in flight from the RAM.
                    if (occ == 3'd0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem.cs     = issue;
    assign mem.oe     = busy;
    assign mem.addr   = issue ? {{(32-ADDR_W){1'b0}}, base_q + issued} : 32'd0;
    assign mem.W_req  = 1'b1;
    assign mem.W_data = 32'd0;

    // The weight is 18 bits wide; re-derive the extension from bit 17 regardless of the upper RAM bits.
    assign push_data       = {{14{mem.R_data[17]}}, mem.R_data[17:0]};
    assign unused_rdata_hi = ^mem.R_data[31:18];

    weight_fifo2 #(.W(32)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pend),
        .push_data (push_data),
        .pop       (pop),
        .head      (out_data),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);
endmodule

// File: tb/tb_weight_sram_reader.sv
// Directed bench for weight_sram_reader with a one-cycle registered SRAM model.
module tb_weight_sram_reader;
    localparam int DEPTH = 81920;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [16:0] base_addr = '0;
    logic [16:0] length = '0;
    logic        busy, done, err, out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    sp_ram_intf mem();

    weight_sram_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mem       (mem)
    );

    always #5 clk = ~clk;

    logic [17:0] sram [DEPTH];

    always @(posedge clk) begin
        if (mem.cs && mem.oe)
            mem.R_data <= {{14{sram[mem.addr[16:0]][17]}}, sram[mem.addr[16:0]]};
    end

    int errors = 0;
    int checks = 0;

    logic [31:0] got [$];
    int   cs_count, first_cs, cs_run, cs_run_max, done_cycle, first_pop, last_pop, viol, busy_seen;
    logic done_err;
    bit   timeout;

    // Runs one command and records what the ports did; protocol breaches accumulate in viol.
    task automatic run_burst(input logic [16:0] b, input logic [16:0] n, input logic [15:0] rpat,
                             input int poke, input int max_cyc);
        int   pushed, pops_done, occ;
        logic cs_prev, stall_prev;
        logic [31:0] data_prev;
        got.delete();
        cs_count = 0; first_cs = -1; cs_run = 0; cs_run_max = 0; done_cycle = -1;
        first_pop = -1; last_pop = -1; viol = 0; busy_seen = 0; done_err = 1'b0; timeout = 0;
        pushed = 0; pops_done = 0; cs_prev = 1'b0; stall_prev = 1'b0; data_prev = '0;
        @(negedge clk);
        base_addr = b; length = n; start = 1'b1;
        for (int k = 0; k <= max_cyc; k++) begin
            out_ready = rpat[k % 16];
            if (k == poke) begin
                start = 1'b1; base_addr = 17'd7; length = 17'd3;
            end
            #1;
            occ = pushed - pops_done;
            if (busy) busy_seen = 1;
            if ((out_valid !== (occ != 0)) || occ > 2) viol++;
            if (stall_prev && out_data !== data_prev) viol++;
            if (mem.cs) begin
                if (mem.addr !== 32'(b) + 32'(cs_count)) viol++;
                if (occ == 2 && !out_ready) viol++;
                cs_count++;
                if (first_cs < 0) first_cs = k;
                cs_run++;
                if (cs_run > cs_run_max) cs_run_max = cs_run;
            end else begin
                cs_run = 0;
            end
            if (busy && !mem.oe) viol++;
            if (mem.W_req !== 1'b1 || mem.W_data !== 32'd0) viol++;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (first_pop < 0) first_pop = k;
                last_pop = k;
                pops_done++;
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
            if (cs_prev) pushed++;
            cs_prev = mem.cs;
            if (done) begin
                done_cycle = k; done_err = err;
                break;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b0;
        if (done_cycle < 0) timeout = 1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, err, out_valid} !== 4'b0000) begin
            errors++; $display("FAIL reset_status: got %b want 0000", {busy, done, err, out_valid});
        end
        checks++;
        if ({mem.cs, mem.oe, mem.W_req} !== 3'b001 || mem.addr !== 32'd0 || mem.W_data !== 32'd0) begin
            errors++; $display("FAIL reset_mem: cs/oe/wreq=%b addr=%0h wdata=%0h want 001/0/0",
                               {mem.cs, mem.oe, mem.W_req}, mem.addr, mem.W_data);
        end
        checks++;
        if (out_data !== 32'd0) begin
            errors++; $display("FAIL reset_data: got %0h want 0", out_data);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] w0;
        sram[5] = 18'h3FFFF;
        run_burst(17'd5, 17'd1, 16'hFFFF, -1, 20);
        w0 = (got.size() > 0) ? got[0] : 32'h0;
        checks++;
        if (got.size() != 1 || w0 !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL single_data: got n=%0d w=%0h want n=1 w=ffffffff", got.size(), w0);
        end
        checks++;
        if (first_cs != 1 || cs_count != 1) begin
            errors++; $display("FAIL single_cs: got first=%0d count=%0d want 1/1", first_cs, cs_count);
        end
        checks++;
        if (first_pop != 3 || done_cycle != 4 || done_err !== 1'b0) begin
            errors++; $display("FAIL single_timing: got pop=%0d done=%0d err=%b want 3/4/0",
                               first_pop, done_cycle, done_err);
        end
        sram[5] = 18'd5;
    endtask

    task automatic test_full_rate();
        int mism = 0;
        run_burst(17'd0, 17'd64, 16'hFFFF, -1, 200);
        foreach (got[i]) if (got[i] !== 32'(i)) mism++;
        checks++;
        if (got.size() != 64 || mism != 0) begin
            errors++; $display("FAIL full_data: got n=%0d bad=%0d want n=64 bad=0", got.size(), mism);
        end
        checks++;
        if (cs_count != 64 || cs_run_max != 64 || first_cs != 1) begin
            errors++; $display("FAIL full_cs: got count=%0d run=%0d first=%0d want 64/64/1",
                               cs_count, cs_run_max, first_cs);
        end
        checks++;
        if (first_pop != 3 || last_pop != 66 || done_cycle != 67) begin
            errors++; $display("FAIL full_timing: got first=%0d last=%0d done=%0d want 3/66/67",
                               first_pop, last_pop, done_cycle);
        end
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL full_protocol: got %0d violations want 0", viol);
        end
    endtask

    task automatic test_backpressure();
        int mism = 0;
        run_burst(17'd100, 17'd16, 16'b1000_1100_0101_1001, -1, 300);
        foreach (got[i]) if (got[i] !== 32'(100 + i)) mism++;
        checks++;
        if (got.size() != 16 || mism != 0) begin
            errors++; $display("FAIL bp_data: got n=%0d bad=%0d want n=16 bad=0", got.size(), mism);
        end
        checks++;
        if (viol != 0 || timeout) begin
            errors++; $display("FAIL bp_protocol: got viol=%0d timeout=%0d want 0/0", viol, timeout);
        end
        checks++;
        if (done_err !== 1'b0 || cs_count != 16) begin
            errors++; $display("FAIL bp_done: got err=%b cs=%0d want 0/16", done_err, cs_count);
        end
    endtask

    task automatic test_bank_cross();
        int mism = 0;
        run_burst(17'd16382, 17'd4, 16'hFFFF, -1, 50);
        foreach (got[i]) if (got[i] !== 32'(16382 + i)) mism++;
        checks++;
        if (got.size() != 4 || mism != 0) begin
            errors++; $display("FAIL bank_data: got n=%0d bad=%0d want n=4 bad=0", got.size(), mism);
        end
        checks++;
        if (cs_run_max != 4 || last_pop - first_pop != 3 || done_cycle != 7) begin
            errors++; $display("FAIL bank_gap: got run=%0d span=%0d done=%0d want 4/3/7",
                               cs_run_max, last_pop - first_pop, done_cycle);
        end
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL bank_protocol: got %0d violations want 0", viol);
        end
    endtask

    task automatic test_illegal();
        logic [16:0] ib [2] = '{17'd0, 17'd81900};
        logic [16:0] il [2] = '{17'd0, 17'd21};
        int mism = 0;
        for (int t = 0; t < 2; t++) begin
            run_burst(ib[t], il[t], 16'hFFFF, -1, 10);
            checks++;
            if (done_cycle != 1 || done_err !== 1'b1 || cs_count != 0 || busy_seen != 0) begin
                errors++; $display("FAIL illegal_%0d: got done=%0d err=%b cs=%0d busy=%0d want 1/1/0/0",
                                   t, done_cycle, done_err, cs_count, busy_seen);
            end
        end
        run_burst(17'd81900, 17'd20, 16'hFFFF, -1, 60);
        foreach (got[i]) if (got[i] !== 32'(81900 + i)) mism++;
        checks++;
        if (done_cycle != 23 || done_err !== 1'b0 || got.size() != 20 || mism != 0) begin
            errors++; $display("FAIL boundary: got done=%0d err=%b n=%0d bad=%0d want 23/0/20/0",
                               done_cycle, done_err, got.size(), mism);
        end
    endtask

    task automatic test_start_ignored();
        int mism = 0;
        int bad = 0;
        run_burst(17'd200, 17'd8, 16'b0110_1011_0101_1101, 4, 100);
        foreach (got[i]) if (got[i] !== 32'(200 + i)) mism++;
        checks++;
        if (got.size() != 8 || mism != 0 || viol != 0) begin
            errors++; $display("FAIL busy_start_data: got n=%0d bad=%0d viol=%0d want 8/0/0",
                               got.size(), mism, viol);
        end
        repeat (6) begin
            @(negedge clk); #1;
            if (mem.cs || busy || done) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL busy_start_queued: got %0d active cycles after done want 0", bad);
        end
    endtask

    task automatic test_reset_mid_burst();
        int pops = 0;
        int bad = 0;
        int mism = 0;
        @(negedge clk);
        base_addr = 17'd0; length = 17'd32; start = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 100 && pops < 10; k++) begin
            #1;
            if (out_valid && out_ready) pops++;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, out_valid, mem.cs, mem.oe, mem.W_req} !== 7'b0000001 ||
            mem.addr !== 32'd0 || out_data !== 32'd0) begin
            errors++; $display("FAIL midrst_outputs: got flags=%b addr=%0h data=%0h want 0000001/0/0",
                               {busy, done, err, out_valid, mem.cs, mem.oe, mem.W_req}, mem.addr, out_data);
        end
        repeat (3) begin
            @(negedge clk); #1;
            if (done || busy || out_valid) bad++;
        end
        rst = 1'b0;
        checks++;
        if (bad != 0 || pops != 10) begin
            errors++; $display("FAIL midrst_quiet: got active=%0d pops=%0d want 0/10", bad, pops);
        end
        run_burst(17'd0, 17'd32, 16'hFFFF, -1, 100);
        foreach (got[i]) if (got[i] !== 32'(i)) mism++;
        checks++;
        if (got.size() != 32 || mism != 0 || done_cycle != 35 || viol != 0) begin
            errors++; $display("FAIL midrst_rerun: got n=%0d bad=%0d done=%0d viol=%0d want 32/0/35/0",
                               got.size(), mism, done_cycle, viol);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) sram[i] = 18'(i);
        mem.R_data = '0;
        test_reset();
        test_single();
        test_full_rate();
        test_backpressure();
        test_bank_cross();
        test_illegal();
        test_start_ignored();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
